// File: rtl/ecc_scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer driving one point-doubling and one point-addition unit.
// Optional per-operation watchdog enabled by defining ECC_CTRL_TIMEOUT_EN.
module ecc_scalar_mult_ctrl #(
  parameter int unsigned n              = 200,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] k,
  input  logic [n-1:0] xp,
  input  logic [n-1:0] yp,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] x_out,
  output logic [n-1:0] y_out,
  output logic         inf_out,
  output logic         err,
  output logic         dbl_reset,
  output logic [n-1:0] dbl_x1,
  output logic [n-1:0] dbl_y1,
  input  logic [n-1:0] dbl_x3,
  input  logic [n-1:0] dbl_y3,
  input  logic         dbl_result,
  input  logic         dbl_infinity,
  output logic         add_reset,
  output logic [n-1:0] add_x1,
  output logic [n-1:0] add_y1,
  output logic [n-1:0] add_x2,
  output logic [n-1:0] add_y2,
  input  logic [n-1:0] add_x3,
  input  logic [n-1:0] add_y3,
  input  logic         add_result,
  input  logic         add_infinity
);

  localparam int unsigned RW = $clog2(n + 1);
`ifdef ECC_CTRL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_SCAN, S_NEXT, S_DBL_GO, S_DBL_WAIT,
    S_ADD_CHK, S_ADD_GO, S_ADD_WAIT, S_DONE
  } state_t;

  state_t state, state_nx;

  // rem = bits still to process below the current pointer; the tested bit is k_sh[n-1]
  logic [n-1:0]  k_sh, k_sh_nx;
  logic [RW-1:0] rem, rem_nx;
  logic [n-1:0]  px, px_nx, py, py_nx, qx, qx_nx, qy, qy_nx;
  logic          q_inf, q_inf_nx;
  logic          via_dbl, via_dbl_nx;
  logic          first, first_nx;
  logic          fin;
`ifdef ECC_CTRL_TIMEOUT_EN
  logic [TW-1:0] cnt, cnt_nx;
`endif

  logic          busy_nx, done_nx, inf_out_nx, err_nx, dbl_reset_nx, add_reset_nx;
  logic [n-1:0]  x_out_nx, y_out_nx, dbl_x1_nx, dbl_y1_nx;
  logic [n-1:0]  add_x1_nx, add_y1_nx, add_x2_nx, add_y2_nx;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_nx   = state;
    k_sh_nx    = k_sh;
    rem_nx     = rem;
    px_nx      = px;
    py_nx      = py;
    qx_nx      = qx;
    qy_nx      = qy;
    q_inf_nx   = q_inf;
    via_dbl_nx = via_dbl;
    first_nx   = first;
    fin        = 1'b0;
`ifdef ECC_CTRL_TIMEOUT_EN
    cnt_nx     = cnt;
`endif
    err_nx     = err;
    x_out_nx   = x_out;
    y_out_nx   = y_out;
    inf_out_nx = inf_out;
    done_nx    = 1'b0;
    dbl_x1_nx  = dbl_x1;
    dbl_y1_nx  = dbl_y1;
    add_x1_nx  = add_x1;
    add_y1_nx  = add_y1;
    add_x2_nx  = add_x2;
    add_y2_nx  = add_y2;

    case (state)
      S_IDLE: begin
        if (start) begin
          k_sh_nx    = k;
          px_nx      = xp;
          py_nx      = yp;
          rem_nx     = RW'(n);
          q_inf_nx   = 1'b0;
          via_dbl_nx = 1'b0;
          err_nx     = 1'b0;
          state_nx   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (k_sh[n-1]) begin
          qx_nx    = px;
          qy_nx    = py;
          q_inf_nx = 1'b0;
          k_sh_nx  = k_sh << 1;
          rem_nx   = rem - RW'(1);
          state_nx = S_NEXT;
        end else if (rem == RW'(1)) begin
          q_inf_nx = 1'b1;
          state_nx = S_DONE;
        end else begin
          k_sh_nx  = k_sh << 1;
          rem_nx   = rem - RW'(1);
        end
      end
      S_NEXT: begin
        if (rem == RW'(0))  state_nx = S_DONE;
        else if (q_inf)     state_nx = S_ADD_CHK;
        else                state_nx = S_DBL_GO;
      end
      S_DBL_GO: begin
        first_nx = 1'b1;
`ifdef ECC_CTRL_TIMEOUT_EN
        cnt_nx   = '0;
`endif
        state_nx = S_DBL_WAIT;
      end
      S_DBL_WAIT: begin
        first_nx = 1'b0;
        if (!first) begin
          if (dbl_infinity) begin
            q_inf_nx = 1'b1;
            fin      = 1'b1;
          end else if (dbl_result) begin
            qx_nx = dbl_x3;
            qy_nx = dbl_y3;
            fin   = 1'b1;
          end
        end
        if (fin) begin
          // A doubling that stood in for an addition (Q==P) completes the add step
          if (via_dbl) begin
            via_dbl_nx = 1'b0;
            k_sh_nx    = k_sh << 1;
            rem_nx     = rem - RW'(1);
            state_nx   = S_NEXT;
          end else begin
            state_nx   = S_ADD_CHK;
          end
        end
`ifdef ECC_CTRL_TIMEOUT_EN
        else if (cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          err_nx   = 1'b1;
          q_inf_nx = 1'b1;
          state_nx = S_DONE;
        end else begin
          cnt_nx = cnt + TW'(1);
        end
`endif
      end
      S_ADD_CHK: begin
        if (!k_sh[n-1]) begin
          k_sh_nx  = k_sh << 1;
          rem_nx   = rem - RW'(1);
          state_nx = S_NEXT;
        end else if (q_inf) begin
          qx_nx    = px;
          qy_nx    = py;
          q_inf_nx = 1'b0;
          k_sh_nx  = k_sh << 1;
          rem_nx   = rem - RW'(1);
          state_nx = S_NEXT;
        end else if (qx == px && qy == py) begin
          via_dbl_nx = 1'b1;
          state_nx   = S_DBL_GO;
        end else begin
          state_nx = S_ADD_GO;
        end
      end
      S_ADD_GO: begin
        first_nx = 1'b1;
`ifdef ECC_CTRL_TIMEOUT_EN
        cnt_nx   = '0;
`endif
        state_nx = S_ADD_WAIT;
      end
      S_ADD_WAIT: begin
        first_nx = 1'b0;
        if (!first) begin
          if (add_infinity) begin
            q_inf_nx = 1'b1;
            fin      = 1'b1;
          end else if (add_result) begin
            qx_nx = add_x3;
            qy_nx = add_y3;
            fin   = 1'b1;
          end
        end
        if (fin) begin
          k_sh_nx  = k_sh << 1;
          rem_nx   = rem - RW'(1);
          state_nx = S_NEXT;
        end
`ifdef ECC_CTRL_TIMEOUT_EN
        else if (cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          err_nx   = 1'b1;
          q_inf_nx = 1'b1;
          state_nx = S_DONE;
        end else begin
          cnt_nx = cnt + TW'(1);
        end
`endif
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    // Registered outputs derived from the upcoming state
    busy_nx      = (state_nx != S_IDLE);
    dbl_reset_nx = (state_nx != S_DBL_WAIT);
    add_reset_nx = (state_nx != S_ADD_WAIT);
    if (state_nx == S_DBL_GO) begin
      dbl_x1_nx = qx;
      dbl_y1_nx = qy;
    end
    if (state_nx == S_ADD_GO) begin
      add_x1_nx = qx;
      add_y1_nx = qy;
      add_x2_nx = px;
      add_y2_nx = py;
    end
    if (state_nx == S_DONE) begin
      done_nx    = 1'b1;
      inf_out_nx = q_inf_nx;
      x_out_nx   = q_inf_nx ? '0 : qx_nx;
      y_out_nx   = q_inf_nx ? '0 : qy_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      k_sh      <= '0;
      rem       <= '0;
      px        <= '0;
      py        <= '0;
      qx        <= '0;
      qy        <= '0;
      q_inf     <= 1'b0;
      via_dbl   <= 1'b0;
      first     <= 1'b0;
`ifdef ECC_CTRL_TIMEOUT_EN
      cnt       <= '0;
`endif
      busy      <= 1'b0;
      done      <= 1'b0;
      inf_out   <= 1'b0;
      err       <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      dbl_reset <= 1'b1;
      add_reset <= 1'b1;
      dbl_x1    <= '0;
      dbl_y1    <= '0;
      add_x1    <= '0;
      add_y1    <= '0;
      add_x2    <= '0;
      add_y2    <= '0;
    end else begin
      state     <= state_nx;
      k_sh      <= k_sh_nx;
      rem       <= rem_nx;
      px        <= px_nx;
      py        <= py_nx;
      qx        <= qx_nx;
      qy        <= qy_nx;
      q_inf     <= q_inf_nx;
      via_dbl   <= via_dbl_nx;
      first     <= first_nx;
`ifdef ECC_CTRL_TIMEOUT_EN
      cnt       <= cnt_nx;
`endif
      busy      <= busy_nx;
      done      <= done_nx;
      inf_out   <= inf_out_nx;
`ifdef ECC_CTRL_TIMEOUT_EN
      err       <= err_nx;
`else
      err       <= 1'b0 & err_nx;
`endif
      x_out     <= x_out_nx;
      y_out     <= y_out_nx;
      dbl_reset <= dbl_reset_nx;
      add_reset <= add_reset_nx;
      dbl_x1    <= dbl_x1_nx;
      dbl_y1    <= dbl_y1_nx;
      add_x1    <= add_x1_nx;
      add_y1    <= add_y1_nx;
      add_x2    <= add_x2_nx;
      add_y2    <= add_y2_nx;
    end
  end

endmodule

// File: doc/ecc_scalar_mult_ctrl.md
Name: ecc_scalar_mult_ctrl

Overview:
- Sequences one point_doubling unit and one point_addition unit to compute Q = k·P by left-to-right double-and-add.
- Owns the per-unit launch protocol: each unit's reset is held high with operands stable, then released, and the controller waits for result or infinity.
- Sits between the top-level scalar-multiplication wrapper and the two arithmetic units.
- p and a go directly from the top level to the units; they do not pass through this block.

Parameters:
n, 200, coordinate and scalar width in bits
TIMEOUT_CYCLES, 4096, per-operation watchdog limit (used only with ECC_CTRL_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  launch request; sampled only in IDLE
k  in  n  scalar; captured on accepted start
xp, yp  in  n each  base point P; captured on accepted start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
x_out, y_out  out  n each  result coordinates; held until next accepted start
inf_out  out  1  result is the point at infinity
err  out  1  watchdog abort flag
dbl_reset  out  1  doubling-unit reset / launch control
dbl_x1, dbl_y1  out  n each  doubling operand
dbl_x3, dbl_y3  in  n each  doubling result
dbl_result, dbl_infinity  in  1 each  doubling completion flags
add_reset  out  1  addition-unit reset / launch control
add_x1, add_y1, add_x2, add_y2  out  n each  addition operands (Q, P)
add_x3, add_y3  in  n each  addition result
add_result, add_infinity  in  1 each  addition completion flags

Behaviour:
- Reset values:
  - busy=0, done=0, err=0, inf_out=0; x_out=y_out=0.
  - dbl_reset=1, add_reset=1.
  - All operand outputs 0; state IDLE.
- Reset mid-operation aborts the run: IDLE on the next cycle, both unit resets high, no done pulse.
- Each unit's reset is 1 in every state except its own *_WAIT state.
- States:
  - IDLE:
    - If start=1: capture k, xp, yp; set bit index i=n-1; go to SCAN.
    - start is ignored in every other state.
  - SCAN:
    - Tests k[i] once per cycle.
    - Bit found set: Q=P, q_inf=0, decrement i, go to NEXT.
    - i passes 0 with no set bit (k==0): q_inf=1, go to DONE. No unit is launched.
  - NEXT:
    - If the bits below the MSB are exhausted, go to DONE.
    - If q_inf=1: doubling is skipped; Q stays infinite.
    - Otherwise go to DBL_GO.
  - DBL_GO (1 cycle): drive dbl_x1/dbl_y1=Q with dbl_reset=1.
  - DBL_WAIT:
    - dbl_reset=0; operands held.
    - Flags are ignored in the first WAIT cycle.
    - dbl_infinity=1 sets q_inf=1. dbl_result=1 loads Q=(dbl_x3,dbl_y3).
    - Next: go to ADD_GO if k[i]=1, else decrement i and go to NEXT.
  - ADD step, when k[i]=1:
    - If q_inf=1: Q=P, q_inf=0, no launch.
    - If Q==P (both coordinates equal): route to DBL_GO instead, operand P.
    - Otherwise ADD_GO (1 cycle, add_reset=1, operands Q,P), then ADD_WAIT with the same flag rules as DBL_WAIT.
    - On completion: decrement i, go to NEXT.
  - DONE (1 cycle):
    - done=1; x_out/y_out=Q; inf_out=q_inf.
    - When inf_out=1, x_out=y_out=0.
    - busy=0 next cycle; return to IDLE.
- A WAIT sample with both result and infinity high: infinity wins.
- Operation count for MSB position m: m doublings plus (popcount(k)−1) additions, minus any skipped operations.

Optional Feature:
- Macro ECC_CTRL_TIMEOUT_EN.
- Defined:
  - A counter starts at 0 on entry to each *_WAIT state.
  - If it reaches TIMEOUT_CYCLES without a flag: err=1, inf_out=1, x_out=y_out=0, done pulse, return to IDLE.
  - err clears on the next accepted start.
- Undefined: no counter; WAIT states wait indefinitely; err is tied 0.

Test Plan:
- k=0, stub units -> done within n+3 cycles of start; inf_out=1; x_out=y_out=0; dbl_reset and add_reset never deasserted.
- k=1, P=(0x11,0x22) -> done; (x_out,y_out)=(0x11,0x22); inf_out=0; zero unit launches.
- k=5 (101b), stub units with 7-cycle latency returning tagged values -> launch order DBL, DBL, ADD; final output equals the ADD stub value.
- k=2, P=(d458e7d1…3e97acf8, 32593050…4086df3b), p=ffff…feffff…ffff, a=ffff…fefff…fffc, real units -> x_out/y_out match a standalone point_doubling run on the same P.
- start pulsed during DBL_WAIT -> ignored. Separately, reset asserted in DBL_WAIT -> busy=0 and dbl_reset=1 on the next cycle, no done pulse.
- ECC_CTRL_TIMEOUT_EN with TIMEOUT_CYCLES=16 and a stub that never flags -> err=1 and done after 16 WAIT cycles; a following valid run clears err.
